// File: rtl/mem_arbiter_if.sv
// Memory-side bus of the CPU's single external memory port.
// The arbiter drives the command fields (master). The memory answers with
// busy/cack/ready and the read data (slave).
interface mem_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 16
);
    logic                  m_read;
    logic                  m_write;
    logic                  m_instr;
    logic [ADDR_W-1:0]     m_addr;
    logic [DATA_W-1:0]     m_wdata;
    logic [2*DATA_W-1:0]   m_rdata;
    logic                  m_busy;
    logic                  m_cack;
    logic                  m_ready;

    modport master (
        output m_read, m_write, m_instr, m_addr, m_wdata,
        input  m_rdata, m_busy, m_cack, m_ready
    );

    modport slave (
        input  m_read, m_write, m_instr, m_addr, m_wdata,
        output m_rdata, m_busy, m_cack, m_ready
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the CPU's external memory port.
// Port 0 is the data path and port 1 is instruction fetch. Each grant carries
// one command through the busy/cack/ready handshake. A timeout aborts a
// command the memory never answers. Every output comes straight from a flop.
module mem_arbiter #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 16,
    parameter int ARB_MODE = 0,     // 0 = round-robin, 1 = port 0 always wins
    parameter int TIMEOUT  = 255    // cycles allowed in ISSUE+WAIT, >= 2
) (
    input  logic                 clk,
    input  logic                 rst_n,

    input  logic                 p0_req,
    input  logic                 p0_we,
    input  logic                 p0_instr,
    input  logic [ADDR_W-1:0]    p0_addr,
    input  logic [DATA_W-1:0]    p0_wdata,
    output logic                 p0_ack,
    output logic                 p0_rdy,
    output logic                 p0_err,

    input  logic                 p1_req,
    input  logic                 p1_we,
    input  logic                 p1_instr,
    input  logic [ADDR_W-1:0]    p1_addr,
    input  logic [DATA_W-1:0]    p1_wdata,
    output logic                 p1_ack,
    output logic                 p1_rdy,
    output logic                 p1_err,

    output logic [2*DATA_W-1:0]  rdata,
    mem_arbiter_if.master        mem,
    output logic                 owner,
    output logic                 active
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  active_q, active_d;
    logic                  m_read_q, m_read_d;
    logic                  m_write_q, m_write_d;
    logic                  m_instr_q, m_instr_d;
    logic [ADDR_W-1:0]     m_addr_q, m_addr_d;
    logic [DATA_W-1:0]     m_wdata_q, m_wdata_d;
    logic [2*DATA_W-1:0]   rdata_q, rdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            ack_q, ack_d;
    logic [1:0]            rdy_q, rdy_d;
    logic [1:0]            err_q, err_d;
    logic                  gnt;
    logic [CNT_W-1:0]      cnt_inc;

    // Cycle counter for the ISSUE+WAIT window. It stops at all-ones rather than wrapping.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    // Next-state, grant selection and output computation.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        m_read_d  = m_read_q;
        m_write_d = m_write_q;
        m_instr_d = m_instr_q;
        m_addr_d  = m_addr_q;
        m_wdata_d = m_wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        ack_d     = 2'b00;
        rdy_d     = 2'b00;
        err_d     = 2'b00;
        gnt       = 1'b0;

        case (state_q)
            IDLE: begin
                if (!mem.m_busy && (p0_req || p1_req)) begin
                    if (ARB_MODE != 0)
                        gnt = ~p0_req;
                    else if (p0_req && p1_req)
                        gnt = ~owner_q;
                    else
                        gnt = p1_req;
                    owner_d   = gnt;
                    m_addr_d  = gnt ? p1_addr  : p0_addr;
                    m_wdata_d = gnt ? p1_wdata : p0_wdata;
                    m_instr_d = gnt ? p1_instr : p0_instr;
                    m_write_d = gnt ? p1_we    : p0_we;
                    m_read_d  = gnt ? ~p1_we   : ~p0_we;
                    cnt_d     = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d = cnt_inc;
                if (mem.m_cack) begin
                    m_read_d       = 1'b0;
                    m_write_d      = 1'b0;
                    ack_d[owner_q] = 1'b1;
                    if (m_write_q) begin
                        state_d = HOLD;
                    end else if (mem.m_ready) begin
                        rdata_d        = mem.m_rdata;
                        rdy_d[owner_q] = 1'b1;
                        state_d        = HOLD;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    m_read_d       = 1'b0;
                    m_write_d      = 1'b0;
                    err_d[owner_q] = 1'b1;
                    state_d        = HOLD;
                end
            end
            WAIT: begin
                cnt_d = cnt_inc;
                if (mem.m_ready) begin
                    rdata_d        = mem.m_rdata;
                    rdy_d[owner_q] = 1'b1;
                    state_d        = HOLD;
                end else if (cnt_q == CNT_LAST) begin
                    err_d[owner_q] = 1'b1;
                    state_d        = HOLD;
                end
            end
            HOLD: begin
                // One dead cycle gives the requester time to drop req after ack/err.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        active_d = (state_d == ISSUE) || (state_d == WAIT);
    end

    // State register. Reset drops the strobes at once, without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            owner_q   <= 1'b1;
            active_q  <= 1'b0;
            m_read_q  <= 1'b0;
            m_write_q <= 1'b0;
            m_instr_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            rdata_q   <= '0;
            cnt_q     <= '0;
            ack_q     <= 2'b00;
            rdy_q     <= 2'b00;
            err_q     <= 2'b00;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            active_q  <= active_d;
            m_read_q  <= m_read_d;
            m_write_q <= m_write_d;
            m_instr_q <= m_instr_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            rdy_q     <= rdy_d;
            err_q     <= err_d;
        end
    end

    assign mem.m_read  = m_read_q;
    assign mem.m_write = m_write_q;
    assign mem.m_instr = m_instr_q;
    assign mem.m_addr  = m_addr_q;
    assign mem.m_wdata = m_wdata_q;

    assign p0_ack = ack_q[0];
    assign p1_ack = ack_q[1];
    assign p0_rdy = rdy_q[0];
    assign p1_rdy = rdy_q[1];
    assign p0_err = err_q[0];
    assign p1_err = err_q[1];
    assign rdata  = rdata_q;
    assign owner  = owner_q;
    assign active = active_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter.
// The main instance uses round-robin with TIMEOUT=8 and a hand-driven memory,
// or an auto-responding memory during the arbitration run. A second instance
// uses fixed priority and always has an auto-responding memory.
module tb_mem_arbiter;

    localparam int AW = 20;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          p0_req = 0, p0_we = 0, p0_instr = 0;
    logic [AW-1:0] p0_addr = '0;
    logic [DW-1:0] p0_wdata = '0;
    logic          p1_req = 0, p1_we = 0, p1_instr = 0;
    logic [AW-1:0] p1_addr = '0;
    logic [DW-1:0] p1_wdata = '0;

    logic          p0_ack, p0_rdy, p0_err, p1_ack, p1_rdy, p1_err, owner, active;
    logic [2*DW-1:0] rdata;
    logic          f_p0_ack, f_p0_rdy, f_p0_err, f_p1_ack, f_p1_rdy, f_p1_err, f_owner, f_active;
    logic [2*DW-1:0] f_rdata;

    logic            auto_mem = 0;
    logic            man_busy = 0, man_cack = 0, man_ready = 0;
    logic [2*DW-1:0] man_rdata = '0;

    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mi ();
    mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fi ();

    // Auto memory accepts and answers in the same cycle the strobe is seen.
    assign mi.m_busy  = auto_mem ? 1'b0 : man_busy;
    assign mi.m_cack  = auto_mem ? (mi.m_read | mi.m_write) : man_cack;
    assign mi.m_ready = auto_mem ? mi.m_read : man_ready;
    assign mi.m_rdata = auto_mem ? {12'h000, mi.m_addr} : man_rdata;

    assign fi.m_busy  = 1'b0;
    assign fi.m_cack  = fi.m_read | fi.m_write;
    assign fi.m_ready = fi.m_read;
    assign fi.m_rdata = {12'h000, fi.m_addr};

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_instr(p0_instr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdy(p0_rdy), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_instr(p1_instr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdy(p1_rdy), .p1_err(p1_err),
        .rdata(rdata), .mem(mi.master), .owner(owner), .active(active)
    );

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1), .TIMEOUT(8)) dut_fix (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_instr(p0_instr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(f_p0_ack), .p0_rdy(f_p0_rdy), .p0_err(f_p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_instr(p1_instr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(f_p1_ack), .p1_rdy(f_p1_rdy), .p1_err(f_p1_err),
        .rdata(f_rdata), .mem(fi.master), .owner(f_owner), .active(f_active)
    );

    int n_chk = 0;
    int n_bad = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    int n_main, n_fix, f_p1_cnt;
    logic seq [4];

    initial begin
        // Reset state
        tick(); tick();
        check_val("rst_owner",  32'(owner), 32'h1);
        check_val("rst_m_read", 32'(mi.m_read), 32'h0);
        check_val("rst_m_write",32'(mi.m_write), 32'h0);
        check_val("rst_m_addr", 32'(mi.m_addr), 32'h0);
        check_val("rst_rdata",  rdata, 32'h0);
        check_val("rst_active", 32'(active), 32'h0);
        rst_n = 1'b1;
        tick();

        // Test 1: single p0 read. Memory busy holds the grant off for one cycle.
        p0_req = 1; p0_we = 0; p0_addr = 20'h12340; man_busy = 1;
        tick();
        check_val("t1_busy_no_strobe", 32'(mi.m_read), 32'h0);
        man_busy = 0;
        tick();
        check_val("t1_m_read",  32'(mi.m_read), 32'h1);
        check_val("t1_m_addr",  32'(mi.m_addr), 32'h12340);
        check_val("t1_owner",   32'(owner), 32'h0);
        check_val("t1_active",  32'(active), 32'h1);
        tick();
        check_val("t1_hold_strobe", 32'(mi.m_read), 32'h1);
        man_cack = 1;
        tick();
        check_val("t1_ack",     32'(p0_ack), 32'h1);
        check_val("t1_m_read_drop", 32'(mi.m_read), 32'h0);
        man_cack = 0; p0_req = 0;
        tick();
        check_val("t1_no_rdy_yet", 32'(p0_rdy), 32'h0);
        man_ready = 1; man_rdata = 32'hDEADBEEF;
        tick();
        check_val("t1_rdy",     32'(p0_rdy), 32'h1);
        check_val("t1_rdata",   rdata, 32'hDEADBEEF);
        check_val("t1_p1_rdy",  32'(p1_rdy), 32'h0);
        man_ready = 0; man_rdata = '0;
        tick();
        check_val("t1_rdata_held", rdata, 32'hDEADBEEF);
        check_val("t1_idle_active", 32'(active), 32'h0);

        // Test 3: p1 write. req stays high through HOLD to show the 3-cycle spacing.
        p1_req = 1; p1_we = 1; p1_addr = 20'h00010; p1_wdata = 16'hA5A5;
        tick();
        check_val("t3_m_write", 32'(mi.m_write), 32'h1);
        check_val("t3_m_read",  32'(mi.m_read), 32'h0);
        check_val("t3_owner",   32'(owner), 32'h1);
        check_val("t3_m_addr",  32'(mi.m_addr), 32'h10);
        check_val("t3_m_wdata", 32'(mi.m_wdata), 32'hA5A5);
        man_cack = 1;
        tick();
        check_val("t3_ack",     32'(p1_ack), 32'h1);
        check_val("t3_p0_ack",  32'(p0_ack), 32'h0);
        check_val("t3_w_drop",  32'(mi.m_write), 32'h0);
        man_cack = 0;
        tick();
        check_val("t3_no_rdy",  32'(p1_rdy), 32'h0);
        check_val("t3_spacing", 32'(mi.m_write), 32'h0);
        tick();
        check_val("t3_reissue", 32'(mi.m_write), 32'h1);
        man_cack = 1;
        tick();
        check_val("t3_ack2",    32'(p1_ack), 32'h1);
        man_cack = 0; p1_req = 0; p1_we = 0;
        tick();

        // Test 4: cack and ready in the same cycle.
        p0_req = 1; p0_we = 0; p0_addr = 20'h00055;
        tick();
        check_val("t4_m_read",  32'(mi.m_read), 32'h1);
        man_cack = 1; man_ready = 1; man_rdata = 32'h12345678;
        tick();
        check_val("t4_ack",     32'(p0_ack), 32'h1);
        check_val("t4_rdy",     32'(p0_rdy), 32'h1);
        check_val("t4_rdata",   rdata, 32'h12345678);
        check_val("t4_hold",    32'(active), 32'h0);
        man_cack = 0; man_ready = 0; p0_req = 0;
        tick();
        check_val("t4_no_cmd",  32'(mi.m_read), 32'h0);
        tick();
        check_val("t4_no_cmd2", 32'(mi.m_read), 32'h0);

        // Test 5: the memory never accepts; abort 8 cycles after the strobe rises.
        p0_req = 1; p0_addr = 20'h00777;
        tick();
        check_val("t5_m_read",  32'(mi.m_read), 32'h1);
        for (int i = 1; i < 8; i++) begin
            tick();
            check_val($sformatf("t5_no_err_%0d", i), 32'(p0_err), 32'h0);
        end
        tick();
        check_val("t5_err",     32'(p0_err), 32'h1);
        check_val("t5_strobe",  32'(mi.m_read), 32'h0);
        check_val("t5_no_ack",  32'(p0_ack), 32'h0);
        check_val("t5_no_rdy",  32'(p0_rdy), 32'h0);
        p0_req = 0;
        tick();
        check_val("t5_err_pulse", 32'(p0_err), 32'h0);

        // Test 6: reset while in WAIT.
        p1_req = 1; p1_addr = 20'h00300;
        tick();
        man_cack = 1;
        tick();
        check_val("t6_ack",     32'(p1_ack), 32'h1);
        man_cack = 0; p1_req = 0;
        tick();
        check_val("t6_wait_active", 32'(active), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_val("t6_async_active", 32'(active), 32'h0);
        check_val("t6_async_read",   32'(mi.m_read), 32'h0);
        check_val("t6_async_owner",  32'(owner), 32'h1);
        tick();
        rst_n = 1'b1; man_ready = 1; man_rdata = 32'hFFFF0000;
        tick();
        check_val("t6_late_rdy", 32'({p0_rdy, p1_rdy}), 32'h0);
        check_val("t6_rdata",    rdata, 32'h0);
        man_ready = 0; man_rdata = '0;

        // Test 2: both ports hold read requests right after reset.
        auto_mem = 1;
        p0_req = 1; p0_we = 0; p0_addr = 20'h00100;
        p1_req = 1; p1_we = 0; p1_addr = 20'h00200;
        n_main = 0; n_fix = 0; f_p1_cnt = 0;
        for (int cyc = 0; cyc < 40 && (n_main < 4 || n_fix < 4); cyc++) begin
            tick();
            if ((p0_ack || p1_ack) && n_main < 4) begin
                seq[n_main] = p1_ack;
                n_main++;
            end
            if (f_p0_ack && n_fix < 4) n_fix++;
            if (f_p1_ack && n_fix < 4) f_p1_cnt++;
        end
        check_val("t2_rr_count", 32'(n_main), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < n_main) check_val($sformatf("t2_rr_grant_%0d", i), 32'(seq[i]), 32'(i % 2));
        end
        check_val("t2_fix_p0_count", 32'(n_fix), 32'd4);
        check_val("t2_fix_p1_count", 32'(f_p1_cnt), 32'd0);
        p0_req = 0; p1_req = 0; auto_mem = 0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
